// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues in-order imem reads
// and buffers returned instructions for decode.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  aq_pc [DEPTH];
  logic [PW-1:0]          aq_rd;
  logic [PW-1:0]          aq_wr;
  logic [ADDR_WIDTH-1:0]  fq_pc [DEPTH];
  logic [INSTR_WIDTH-1:0] fq_instr [DEPTH];
  logic [PW-1:0]          fq_rd;
  logic [PW-1:0]          fq_wr;
  logic [CW-1:0]          inflight_cnt;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          fifo_cnt;

  logic [CW:0] occ;
  logic        credit;
  logic        req_fire;
  logic        rsp_live;
  logic        pop;

  // Credits count dropped responses too, so every
  // response that lands is guaranteed a FIFO slot.
  assign occ = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign credit = (32'(occ) < DEPTH);
  assign imem_req_valid = rst_n & credit & ~redirect_valid;
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_live = imem_rsp_valid & (drop_cnt == '0);
  assign if_valid = (fifo_cnt != '0);
  assign pop = if_valid & if_ready;
  assign if_pc = if_valid ? fq_pc[fq_rd] : '0;
  assign if_instr = if_valid ? fq_instr[fq_rd] : '0;

  // PC, counters and pointers; redirect flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight_cnt <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      aq_rd <= '0;
      aq_wr <= '0;
      fq_rd <= '0;
      fq_wr <= '0;
    end else begin
      inflight_cnt <= inflight_cnt + CW'(req_fire)
                      - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
        drop_cnt <= inflight_cnt - CW'(imem_rsp_valid);
        fifo_cnt <= '0;
        aq_rd <= '0;
        aq_wr <= '0;
        fq_rd <= '0;
        fq_wr <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
          aq_wr <= aq_wr + PW'(1);
        end
        if (imem_rsp_valid && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (rsp_live) begin
          aq_rd <= aq_rd + PW'(1);
          fq_wr <= fq_wr + PW'(1);
        end
        if (pop) begin
          fq_rd <= fq_rd + PW'(1);
        end
        fifo_cnt <= fifo_cnt + CW'(rsp_live) - CW'(pop);
      end
    end
  end

  // Address queue and instruction FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        aq_pc[i] <= '0;
        fq_pc[i] <= '0;
        fq_instr[i] <= '0;
      end
    end else begin
      if (req_fire) begin
        aq_pc[aq_wr] <= fetch_pc;
      end
      if (rsp_live && !redirect_valid) begin
        fq_pc[fq_wr] <= aq_pc[aq_rd];
        fq_instr[fq_wr] <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a
// variable-latency in-order instruction memory.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  typedef struct {
    logic [63:0] a;
    int          due;
  } mreq_t;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  mreq_t       mq[$];
  ent_t        got[$];
  logic [63:0] reqlog[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rdy_rand = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        ok;
  logic [63:0] ph;
  logic [63:0] last;
  int          nb;
  int          n5;

  fetch_unit #(
    .ADDR_WIDTH(64),
    .INSTR_WIDTH(32),
    .RESET_PC(64'h1000),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_pc(if_pc),
    .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] idata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0bad_c0de;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag,
                              input logic [63:0] base,
                              input int n);
    check({tag, "_len"}, 64'(got.size() >= n), 64'd1);
    for (int i = 0; i < n && i < got.size(); i++) begin
      logic [63:0] e;
      e = base + 64'(4 * i);
      check($sformatf("%s_pc%0d", tag, i), got[i].pc, e);
      check($sformatf("%s_in%0d", tag, i),
            64'(got[i].ins), 64'(idata(e)));
    end
  endtask

  // In-order memory: response lat cycles after acceptance
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (imem_rsp_valid) begin
        assert (mq.size() > 0) else
          $error("FAIL protocol: response with none outstanding");
        void'(mq.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cyc + lat});
        reqlog.push_back(imem_req_addr);
      end
    end
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = idata(mq[0].a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
    end
    if (rdy_rand) imem_req_ready = ($urandom_range(0, 3) != 0);
    else imem_req_ready = 1'b1;
  end

  // Decode-side monitor
  always @(posedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      got.push_back('{if_pc, if_instr});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    #12;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, 64'h1000);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);

    // sequential fetch after release
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("c1_req_valid", 64'(imem_req_valid), 64'd1);
    check("c1_req_addr", imem_req_addr, 64'h1000);
    check("c1_if_valid", 64'(if_valid), 64'd0);
    @(negedge clk); #1;
    check("c2_req_valid", 64'(imem_req_valid), 64'd1);
    check("c2_req_addr", imem_req_addr, 64'h1004);
    check("c2_if_valid", 64'(if_valid), 64'd0);
    @(negedge clk); #1;
    check("c3_if_valid", 64'(if_valid), 64'd1);
    check("c3_if_pc", if_pc, 64'h1000);
    check("c3_if_instr", 64'(if_instr), 64'(idata(64'h1000)));
    check("c3_req_valid", 64'(imem_req_valid), 64'd0);
    @(negedge clk); #1;
    check("c4_req_valid", 64'(imem_req_valid), 64'd1);
    check("c4_req_addr", imem_req_addr, 64'h1008);
    check("c4_if_pc", if_pc, 64'h1004);
    repeat (12) @(negedge clk);
    check_stream("seq", 64'h1000, 6);

    // backpressure from a fresh redirect
    @(negedge clk);
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("bp_r1_addr", imem_req_addr, 64'h3000);
    check("bp_r1_if_valid", 64'(if_valid), 64'd0);
    reqlog.delete();
    got.delete();
    repeat (10) @(negedge clk);
    #1;
    check("bp_req_valid", 64'(imem_req_valid), 64'd0);
    check("bp_nreq", 64'(reqlog.size()), 64'd2);
    check("bp_req0", reqlog[0], 64'h3000);
    check("bp_req1", reqlog[1], 64'h3004);
    check("bp_if_pc", if_pc, 64'h3000);
    check("bp_no_pop", 64'(got.size()), 64'd0);
    if_ready = 1'b1;
    rdy_rand = 1'b1;
    repeat (40) @(negedge clk);
    rdy_rand = 1'b0;
    check_stream("bp", 64'h3000, 6);

    // redirect with two requests in flight
    lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (mq.size() == 2) && !imem_rsp_valid;
    end
    check("r3_wait", 64'(ok), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2002;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("r3_addr", imem_req_addr, 64'h2000);
    check("r3_if_valid", 64'(if_valid), 64'd0);
    check("r3_req_valid", 64'(imem_req_valid), 64'd0);
    got.delete();
    repeat (25) @(negedge clk);
    check_stream("r3", 64'h2000, 3);

    // redirect with coincident response and pop
    lat = 1;
    repeat (8) @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = imem_rsp_valid && if_valid;
    end
    check("r4_wait", 64'(ok), 64'd1);
    ph = if_pc;
    nb = got.size();
    redirect_valid = 1'b1;
    redirect_pc = 64'h4000;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    last = (got.size() > 0) ? got[got.size() - 1].pc : '0;
    check("r4_pop_n", 64'(got.size()), 64'(nb + 1));
    check("r4_pop_pc", last, ph);
    check("r4_if_valid", 64'(if_valid), 64'd0);
    check("r4_addr", imem_req_addr, 64'h4000);
    check("r4_req_valid", 64'(imem_req_valid), 64'd1);
    got.delete();
    repeat (15) @(negedge clk);
    check_stream("r4", 64'h4000, 3);

    // wrap-around of the fetch PC
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("w_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    reqlog.delete();
    got.delete();
    repeat (15) @(negedge clk);
    check("w_nreq", 64'(reqlog.size() >= 3), 64'd1);
    check("w_req0", reqlog[0], 64'hFFFF_FFFF_FFFF_FFFC);
    check("w_req1", reqlog[1], 64'h0);
    check("w_req2", reqlog[2], 64'h4);
    check_stream("w", 64'hFFFF_FFFF_FFFF_FFFC, 3);

    // back-to-back redirects: second target wins
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h5000;
    @(negedge clk);
    redirect_pc = 64'h6003;
    #1;
    check("bb_req_valid", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("bb_addr", imem_req_addr, 64'h6000);
    check("bb_if_valid", 64'(if_valid), 64'd0);
    reqlog.delete();
    got.delete();
    repeat (15) @(negedge clk);
    check("bb_req0", reqlog[0], 64'h6000);
    check_stream("bb", 64'h6000, 3);
    n5 = 0;
    foreach (got[i]) if (got[i].pc[63:8] == 56'h50) n5++;
    foreach (reqlog[i]) if (reqlog[i][63:8] == 56'h50) n5++;
    check("bb_no_a_path", 64'(n5), 64'd0);

    // async reset with requests in flight
    lat = 3;
    repeat (6) @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (mq.size() > 0);
    end
    check("ar_wait", 64'(ok), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req_valid", 64'(imem_req_valid), 64'd0);
    check("ar_req_addr", imem_req_addr, 64'h1000);
    check("ar_if_valid", 64'(if_valid), 64'd0);
    check("ar_if_pc", if_pc, 64'd0);
    check("ar_if_instr", 64'(if_instr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    got.delete();
    reqlog.delete();
    rst_n = 1'b1;
    #1;
    check("ar_c1_valid", 64'(imem_req_valid), 64'd1);
    check("ar_c1_addr", imem_req_addr, 64'h1000);
    repeat (25) @(negedge clk);
    check("ar_req0", reqlog[0], 64'h1000);
    check_stream("ar", 64'h1000, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
